// File: rtl/mc_pkg.sv
// Shared constants and control-vector type for the multicycle MIPS sequencer.
// Optional jump support is controlled by the MC_SEQ_JUMP_EN macro.
package mc_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMRD    = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWR    = 4'd5;
    localparam logic [3:0] ST_RTYPE_EX = 4'd6;
    localparam logic [3:0] ST_ALUWB    = 4'd7;
    localparam logic [3:0] ST_BEQ      = 4'd8;
    localparam logic [3:0] ST_ADDI_EX  = 4'd9;
    localparam logic [3:0] ST_ADDI_WB  = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_TRAP     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal;
    } ctrl_t;

    // States whose exit into FETCH completes an instruction.
    function automatic logic retires_on_exit(input logic [3:0] st);
        return (st == ST_MEMWB) || (st == ST_MEMWR) || (st == ST_ALUWB) ||
               (st == ST_BEQ) || (st == ST_ADDI_WB) || (st == ST_JUMP);
    endfunction

endpackage

// File: rtl/mc_seq_outdec.sv
// Combinational decode of sequencer state plus memory/zero handshakes into
// the datapath control vector. JUMP decode exists only with MC_SEQ_JUMP_EN.
module mc_seq_outdec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       reset,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        ctrl = '0;
        if (!reset) begin
            unique case (state)
                ST_FETCH: begin
                    ctrl.mem_req   = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_src    = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_en     = mem_ready;
                end
                ST_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                ST_MEMADR, ST_ADDI_EX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                ST_MEMRD: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.iord    = 1'b1;
                end
                ST_MEMWB: begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end
                ST_MEMWR: begin
                    ctrl.mem_req   = 1'b1;
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                ST_RTYPE_EX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                ST_ALUWB: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                ST_BEQ: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_SUB;
                    ctrl.pc_src    = PCSRC_ALUOUT;
                    ctrl.pc_en     = zero;
                end
                ST_ADDI_WB: begin
                    ctrl.reg_write = 1'b1;
                end
`ifdef MC_SEQ_JUMP_EN
                ST_JUMP: begin
                    ctrl.pc_src = PCSRC_JUMP;
                    ctrl.pc_en  = 1'b1;
                end
`endif
                ST_TRAP: begin
                    ctrl.illegal = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle MIPS control sequencer: state register, next-state logic and
// retired-instruction counter. Define MC_SEQ_JUMP_EN to decode j (opcode 2).
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             pc_en,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_next;
    ctrl_t            w_ctrl;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_FETCH:    if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_RTYPE:     w_next = ST_RTYPE_EX;
                    OP_BEQ:       w_next = ST_BEQ;
                    OP_ADDI:      w_next = ST_ADDI_EX;
`ifdef MC_SEQ_JUMP_EN
                    OP_J:         w_next = ST_JUMP;
`endif
                    default:      w_next = ST_TRAP;
                endcase
            end
            ST_MEMADR:   w_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:    if (mem_ready) w_next = ST_MEMWB;
            ST_MEMWR:    if (mem_ready) w_next = ST_FETCH;
            ST_RTYPE_EX: w_next = ST_ALUWB;
            ST_ADDI_EX:  w_next = ST_ADDI_WB;
            ST_MEMWB, ST_ALUWB, ST_BEQ, ST_ADDI_WB: w_next = ST_FETCH;
`ifdef MC_SEQ_JUMP_EN
            ST_JUMP:     w_next = ST_FETCH;
`endif
            ST_TRAP:     w_next = ST_TRAP;
            // Unused encodings are treated as corruption and trapped.
            default:     w_next = ST_TRAP;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            r_state   <= ST_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_FETCH && retires_on_exit(r_state))
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    mc_seq_outdec u_outdec (
        .state     (r_state),
        .reset     (reset),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (w_ctrl)
    );

    assign mem_req  = w_ctrl.mem_req;
    assign IorD     = w_ctrl.iord;
    assign MemWrite = w_ctrl.mem_write;
    assign IRWrite  = w_ctrl.ir_write;
    assign RegDst   = w_ctrl.reg_dst;
    assign MemtoReg = w_ctrl.mem_to_reg;
    assign RegWrite = w_ctrl.reg_write;
    assign ALUSrcA  = w_ctrl.alu_src_a;
    assign ALUSrcB  = w_ctrl.alu_src_b;
    assign ALUOp    = w_ctrl.alu_op;
    assign PCSrc    = w_ctrl.pc_src;
    assign pc_en    = w_ctrl.pc_en;
    assign illegal  = w_ctrl.illegal;
    assign state    = r_state;
    assign retired  = r_retired;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized bench for mc_sequencer: each instruction is modelled as a route of
// phases, and expected controls come from a per-phase table.
module tb_mc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, pc_en, illegal;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
    logic [3:0]  state;
    logic [31:0] retired;

    always #5 clock = ~clock;

    mc_sequencer #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .pc_en(pc_en), .illegal(illegal),
        .state(state), .retired(retired)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: phase list of the current instruction, position in it, retired count.
    int          route[$];
    int          idx;
    logic [31:0] m_retired;
    int          trap_cycles;
    logic [5:0]  forced_ops[$];
    logic [5:0]  legal_ops[6] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};
    logic [5:0]  bad_ops[6]   = '{6'd1, 6'd3, 6'd5, 6'd9, 6'd16, 6'd63};

    task automatic new_instr();
        logic [5:0] op;
        if (forced_ops.size() > 0) op = forced_ops.pop_front();
        else if ($urandom_range(0, 11) == 0) op = bad_ops[$urandom_range(0, 5)];
        else op = legal_ops[$urandom_range(0, 5)];
        opcode = op;
        idx = 0;
        route = '{0, 1};
        case (op)
            6'd35: begin route.push_back(2); route.push_back(3); route.push_back(4); end
            6'd43: begin route.push_back(2); route.push_back(5); end
            6'd0:  begin route.push_back(6); route.push_back(7); end
            6'd4:  route.push_back(8);
            6'd8:  begin route.push_back(9); route.push_back(10); end
`ifdef MC_SEQ_JUMP_EN
            6'd2:  route.push_back(11);
`endif
            default: route.push_back(15);
        endcase
    endtask

    // Expected control vector laid out as
    // {mem_req,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,pc_en,illegal}.
    function automatic logic [18:0] exp_ctrl(input int s, input logic mr, input logic z);
        logic mq = 0, io = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pe = 0, il = 0;
        logic [1:0] sb = 0, op = 0, ps = 0;
        case (s)
            0:  begin mq = 1; sb = 2'b01; irw = mr; pe = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mq = 1; io = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mq = 1; io = 1; mw = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; op = 2'b01; ps = 2'b01; pe = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            15: il = 1;
            default: ;
        endcase
        return {mq, io, mw, irw, rd, m2r, rw, sa, sb, op, ps, pe, il};
    endfunction

    // One clock: drive inputs, check at the falling edge, advance the model after the rising edge.
    task automatic cycle(input logic rst, input logic mr, input logic z);
        logic [18:0] got;
        int s;
        reset = rst; mem_ready = mr; zero = z;
        @(negedge clock);
        s = route[idx];
        got = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, pc_en, illegal};
        if (rst) begin
            check("ctrl_in_reset", {13'd0, got}, 32'd0);
        end else begin
            check("state", {28'd0, state}, s);
            check("ctrl", {13'd0, got}, {13'd0, exp_ctrl(s, mr, z)});
            check("retired", retired, m_retired);
        end
        @(posedge clock);
        #1;
        if (rst) begin
            m_retired = 0;
            trap_cycles = 0;
            new_instr();
        end else if (s == 15) begin
            trap_cycles++;
        end else if ((s == 0 || s == 3 || s == 5) && !mr) begin
            // memory stall: phase repeats
        end else if (idx == route.size() - 1) begin
            m_retired++;
            new_instr();
        end else begin
            idx++;
        end
    endtask

    task automatic run(input int n, input int ready_pct, input int reset_pct);
        for (int i = 0; i < n; i++) begin
            logic rst = ($urandom_range(0, 99) < reset_pct) || (trap_cycles >= 20);
            cycle(rst, $urandom_range(0, 99) < ready_pct, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        reset = 1; mem_ready = 0; zero = 0; opcode = 0;
        m_retired = 0; trap_cycles = 0;
        new_instr();
        cycle(1, 0, 0);
        // Directed order: lw, sw, beq, beq, R-type, addi, j, illegal, then random.
        forced_ops = '{6'd35, 6'd43, 6'd4, 6'd4, 6'd0, 6'd8, 6'd2, 6'd63};
        cycle(1, 1, 0);
        run(30, 100, 0);
        run(25, 100, 0);
        forced_ops = '{6'd43};
        cycle(1, 1, 0);
        for (int i = 0; i < 12; i++) cycle(0, route[idx] == 5 ? (i >= 8) : 1'b1, 1'b0);
        run(3000, 70, 1);
        // Reset asserted while a load is stalled in MEMRD.
        forced_ops = '{6'd35};
        cycle(1, 1, 0);
        for (int i = 0; i < 10 && route[idx] != 3; i++) cycle(0, 1, 0);
        check("reach_memrd", {28'd0, state}, route[idx]);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        check("retired_after_rst", retired, 32'd0);
        run(40, 80, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multicycle control sequencer for the MIPS datapath.
- Replaces the single-cycle combinational main decoder with a Moore-style FSM that steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB across several clocks.
- Shares one ALU and one unified memory port across the instruction phases.
- Stalls on a memory ready handshake, traps on illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction register bits [31:26]; held stable while IRWrite=0.
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  address select: 0 = PC, 1 = ALUOut register.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load instruction register.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = memory data register.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  to ALUControl: 00 = add, 01 = sub, 10 = funct.
- PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- pc_en  out  1  PC register load enable.
- illegal  out  1  trap indicator.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: single clock, named clock. Reset is synchronous and active-high, named reset.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, ALUWB=7, BEQ=8, ADDI_EX=9, ADDI_WB=10, JUMP=11, TRAP=15.
- Reset response: state <= FETCH, retired <= 0.
- Outputs during reset: while reset=1, every control output is forced to 0, including mem_req, pc_en and illegal.
- Output timing: outputs are combinational decodes of state. Only mem_ready and zero are used in Mealy fashion, as listed below. Any output not listed for a state is 0.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = pc_en = mem_ready.
  - Go to DECODE when mem_ready=1; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by opcode:
  - 35 or 43 -> MEMADR.
  - 0 -> RTYPE_EX.
  - 4 -> BEQ.
  - 8 -> ADDI_EX.
  - 2 -> JUMP (only when the feature below is enabled).
  - any other -> TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if opcode=35, else MEMWR.
- MEMRD: mem_req=1, IorD=1. Stay until mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1, held for the whole stall. Go to FETCH on mem_ready.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Go to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, pc_en=zero. Go to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDI_WB.
- ADDI_WB: RegDst=0, RegWrite=1. Go to FETCH.
- JUMP: PCSrc=10, pc_en=1. Go to FETCH.
- TRAP: illegal=1, all other outputs 0. Stays in TRAP until reset.
- Retired counter:
  - Increments by 1 on each edge that moves the FSM into FETCH from MEMWB, MEMWR, ALUWB, BEQ, ADDI_WB or JUMP.
  - Wraps modulo 2^CNT_W.
  - Does not increment on entry to TRAP.
- Zero-wait latency: beq=3, j=3, R-type=4, sw=4, addi=4, lw=5 cycles. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset mid-instruction: the instruction is abandoned, no register or memory write occurs in the reset cycle, and retired is cleared.
- Unknown funct is not detected here; it is ALUControl's responsibility.

Optional Feature:
- Macro: MC_SEQ_JUMP_EN.
- Defined: opcode 2 decodes to the JUMP state.
- Undefined: the JUMP state is not generated, opcode 2 goes to TRAP, and PCSrc never takes the value 10.

Decomposition:
- Shared package mc_pkg holds:
  - the state encoding constants;
  - opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_LW=35, OP_SW=43;
  - ALUOp and ALUSrcB/PCSrc encoding constants.
- One natural sub-module: mc_seq_outdec, a purely combinational state-plus-handshake to control-vector decoder. The FSM registers and the counter stay in mc_sequencer.

Test Plan:
- Reset, then lw (opcode 35) with mem_ready tied to 1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in MEMWB; retired=1 after 5 cycles.
- sw (43) with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles; no pc_en pulse outside FETCH; retired increments once.
- beq with zero=1, then beq with zero=0 -> pc_en=1 with PCSrc=01 in the first BEQ state; pc_en=0 in the second; each takes 3 cycles.
- R-type followed by addi (8) -> ALUOp=10 in RTYPE_EX, ALUOp=00 with ALUSrcB=10 in ADDI_EX; RegDst=1 then 0; retired=2.
- opcode 63 -> TRAP (state=15), illegal=1, all write enables 0 for 20 cycles; reset -> FETCH with retired=0. Opcode 2 with MC_SEQ_JUMP_EN undefined -> also TRAP.
- Assert reset in MEMRD during a stall -> next state FETCH, no RegWrite; with MC_SEQ_JUMP_EN defined, j -> PCSrc=10 and pc_en=1 in JUMP.
